// File: rtl/rapids_pkg.sv
// rapids_pkg: shared types and constants for the fetch front end.
package rapids_pkg;
  typedef enum logic [1:0] {FETCH, DRAIN, HOLD} fetch_state_t;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0;
endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: single-outstanding instruction memory read bus.
interface instr_fetch_if
  import rapids_pkg::*;
#(
  parameter int ADDR_W = 32
);
  logic               req;
  logic [ADDR_W-1:0]  addr;
  logic               rvalid;
  logic [INSTR_W-1:0] rdata;
  modport master (output req, addr, input rvalid, rdata);
  modport slave  (input req, addr, output rvalid, rdata);
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: pc register, single-outstanding instruction fetch and instruction register
// feeding controlpath; redirects drop stale in-flight responses.
module instr_fetch
  import rapids_pkg::*;
#(
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int                 PC_STEP  = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               pc_inc,
  input  logic               jump_valid,
  input  logic [ADDR_W-1:0]  jump_target,
  instr_fetch_if.master      mem,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc
);
  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d, fetch_addr_q, fetch_addr_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               instr_valid_q, instr_valid_d;

  // Jump beats increment; targets are silently word-aligned.
  function automatic logic [ADDR_W-1:0] pc_next(input logic jmp, input logic inc,
                                                 input logic [ADDR_W-1:0] cur,
                                                 input logic [ADDR_W-1:0] tgt);
    return jmp ? (tgt & ~ADDR_W'(3)) : inc ? cur + ADDR_W'(PC_STEP) : cur;
  endfunction

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_addr_d  = fetch_addr_q;
    ir_d          = ir_q;
    instr_valid_d = instr_valid_q;
    case (state_q)
      FETCH: begin
        pc_d = pc_next(jump_valid, 1'b0, pc_q, jump_target);
        if (jump_valid) begin
          fetch_addr_d = mem.rvalid ? pc_d : fetch_addr_q;
          state_d      = mem.rvalid ? FETCH : DRAIN;
        end else if (mem.rvalid) begin
          ir_d          = mem.rdata;
          instr_valid_d = 1'b1;
          state_d       = HOLD;
        end
      end
      HOLD: begin
        pc_d = pc_next(jump_valid, pc_inc, pc_q, jump_target);
        if (jump_valid || pc_inc) begin
          fetch_addr_d  = pc_d;
          instr_valid_d = 1'b0;
          state_d       = FETCH;
        end
      end
      DRAIN: begin
        // Address stays on the old request until it completes; only pc follows jumps.
        pc_d = pc_next(jump_valid, 1'b0, pc_q, jump_target);
        if (mem.rvalid) begin
          fetch_addr_d = pc_d;
          state_d      = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      fetch_addr_q  <= RESET_PC;
      ir_q          <= NOP_WORD;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_addr_q  <= fetch_addr_d;
      ir_q          <= ir_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign mem.req     = resetn && (state_q != HOLD);
  assign mem.addr    = fetch_addr_q;
  assign instruction = instr_valid_q ? ir_q : NOP_WORD;
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;

  a_pc_inc_in_hold: assert property (@(posedge clk) disable iff (!resetn)
    pc_inc |-> state_q == HOLD)
    else $error("pc_inc outside HOLD");
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed vector table plus reset-in-DRAIN sequence for instr_fetch.
module tb_instr_fetch;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        pc_inc = 1'b0;
  logic        jump_valid = 1'b0;
  logic [31:0] jump_target = '0;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [31:0] pc;
  int          checks = 0;
  int          failures = 0;

  instr_fetch_if #(.ADDR_W(32)) bus ();

  instr_fetch #(.ADDR_W(32), .RESET_PC(32'h0), .PC_STEP(4)) dut (
    .clk(clk), .resetn(resetn), .pc_inc(pc_inc), .jump_valid(jump_valid),
    .jump_target(jump_target), .mem(bus), .instruction(instruction),
    .instr_valid(instr_valid), .pc(pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        inc;
    logic        jv;
    logic [31:0] jt;
    logic        rv;
    logic [31:0] rd;
    logic        req;
    logic [31:0] addr;
    logic        v;
    logic [31:0] ins;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl[28];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic req, input logic [31:0] addr,
                         input logic v, input logic [31:0] ins, input logic [31:0] p);
    chk({tag, " mem_req"}, {31'b0, bus.req}, {31'b0, req});
    chk({tag, " mem_addr"}, bus.addr, addr);
    chk({tag, " instr_valid"}, {31'b0, instr_valid}, {31'b0, v});
    chk({tag, " instruction"}, instruction, ins);
    chk({tag, " pc"}, pc, p);
  endtask

  initial begin
    tbl[0]  = '{0, 0, 32'h0,        0, 32'h0,         1, 32'h0,        0, 32'h0,         32'h0};
    tbl[1]  = '{0, 0, 32'h0,        0, 32'h0,         1, 32'h0,        0, 32'h0,         32'h0};
    tbl[2]  = '{0, 0, 32'h0,        1, 32'hDEAD_0001, 1, 32'h0,        0, 32'h0,         32'h0};
    tbl[3]  = '{1, 0, 32'h0,        0, 32'h0,         0, 32'h0,        1, 32'hDEAD_0001, 32'h0};
    tbl[4]  = '{0, 0, 32'h0,        1, 32'h1111_1111, 1, 32'h4,        0, 32'h0,         32'h4};
    tbl[5]  = '{1, 0, 32'h0,        0, 32'h0,         0, 32'h4,        1, 32'h1111_1111, 32'h4};
    tbl[6]  = '{0, 0, 32'h0,        1, 32'h2222_2222, 1, 32'h8,        0, 32'h0,         32'h8};
    tbl[7]  = '{1, 0, 32'h0,        0, 32'h0,         0, 32'h8,        1, 32'h2222_2222, 32'h8};
    tbl[8]  = '{0, 0, 32'h0,        1, 32'h3333_3333, 1, 32'hC,        0, 32'h0,         32'hC};
    tbl[9]  = '{0, 1, 32'hFFFF_FFFF, 0, 32'h0,        0, 32'hC,        1, 32'h3333_3333, 32'hC};
    tbl[10] = '{0, 0, 32'h0,        1, 32'h4444_4444, 1, 32'hFFFF_FFFC, 0, 32'h0,        32'hFFFF_FFFC};
    tbl[11] = '{1, 0, 32'h0,        0, 32'h0,         0, 32'hFFFF_FFFC, 1, 32'h4444_4444, 32'hFFFF_FFFC};
    tbl[12] = '{0, 0, 32'h0,        1, 32'h5555_5555, 1, 32'h0,        0, 32'h0,         32'h0};
    tbl[13] = '{1, 0, 32'h0,        0, 32'h0,         0, 32'h0,        1, 32'h5555_5555, 32'h0};
    tbl[14] = '{0, 1, 32'h103,      0, 32'h0,         1, 32'h4,        0, 32'h0,         32'h4};
    tbl[15] = '{0, 0, 32'h0,        0, 32'h0,         1, 32'h4,        0, 32'h0,         32'h100};
    tbl[16] = '{0, 0, 32'h0,        0, 32'h0,         1, 32'h4,        0, 32'h0,         32'h100};
    tbl[17] = '{0, 0, 32'h0,        1, 32'hBAD,       1, 32'h4,        0, 32'h0,         32'h100};
    tbl[18] = '{0, 0, 32'h0,        0, 32'h0,         1, 32'h100,      0, 32'h0,         32'h100};
    tbl[19] = '{0, 0, 32'h0,        1, 32'h6666_6666, 1, 32'h100,      0, 32'h0,         32'h100};
    tbl[20] = '{1, 1, 32'h40,       0, 32'h0,         0, 32'h100,      1, 32'h6666_6666, 32'h100};
    tbl[21] = '{0, 1, 32'h200,      1, 32'h7777_7777, 1, 32'h40,       0, 32'h0,         32'h40};
    tbl[22] = '{0, 0, 32'h0,        1, 32'h8888_8888, 1, 32'h200,      0, 32'h0,         32'h200};
    tbl[23] = '{0, 0, 32'h0,        1, 32'h99,        0, 32'h200,      1, 32'h8888_8888, 32'h200};
    tbl[24] = '{1, 0, 32'h0,        0, 32'h0,         0, 32'h200,      1, 32'h8888_8888, 32'h200};
    tbl[25] = '{0, 1, 32'h300,      0, 32'h0,         1, 32'h204,      0, 32'h0,         32'h204};
    tbl[26] = '{0, 1, 32'h404,      1, 32'h0,         1, 32'h204,      0, 32'h0,         32'h300};
    tbl[27] = '{0, 1, 32'h500,      0, 32'h0,         1, 32'h404,      0, 32'h0,         32'h404};
    bus.rvalid = 1'b0;
    bus.rdata  = '0;
    repeat (2) @(negedge clk);
    #1 chk_all("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 28; i++) begin
      pc_inc      = tbl[i].inc;
      jump_valid  = tbl[i].jv;
      jump_target = tbl[i].jt;
      bus.rvalid  = tbl[i].rv;
      bus.rdata   = tbl[i].rd;
      #1 chk_all($sformatf("row%0d", i), tbl[i].req, tbl[i].addr, tbl[i].v, tbl[i].ins, tbl[i].pc);
      @(negedge clk);
    end
    // Reset asserted mid-DRAIN must clear outputs without waiting for a clock.
    pc_inc = 1'b0; jump_valid = 1'b0; jump_target = '0; bus.rvalid = 1'b0; bus.rdata = '0;
    #1 chk_all("drain", 1'b1, 32'h404, 1'b0, 32'h0, 32'h500);
    #2 resetn = 1'b0;
    #1 chk_all("async_rst", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    #1 chk_all("restart", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    bus.rvalid = 1'b1;
    bus.rdata  = 32'hABCD_0123;
    @(negedge clk);
    bus.rvalid = 1'b0;
    #1 chk_all("restart_hold", 1'b0, 32'h0, 1'b1, 32'hABCD_0123, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Front-end stage directly upstream of controlpath.
- Holds the program counter and issues single-outstanding instruction reads to instruction memory.
- Captures the returned word into an instruction register and presents it on `instruction` to controlpath.
- Advances on controlpath's `pc_inc` pulse and redirects on `jump_valid`, discarding any in-flight stale fetch.

Parameters:
- ADDR_W, 32, width of pc and memory address
- RESET_PC, 32'h0000_0000, pc value loaded on reset (must be 4-byte aligned)
- PC_STEP, 4, byte increment per sequential instruction

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- pc_inc  in  1  from controlpath; current instruction consumed, fetch next sequential
- jump_valid  in  1  redirect request (one-cycle pulse)
- jump_target  in  ADDR_W  redirect byte address
- mem_req  out  1  read request; held high until mem_rvalid
- mem_addr  out  ADDR_W  read address; stable while mem_req high
- mem_rvalid  in  1  read data valid; completes the outstanding request
- mem_rdata  in  32  read data
- instruction  out  32  to controlpath decoder; 32'h0 when instr_valid low
- instr_valid  out  1  instruction register holds a valid word for pc
- pc  out  ADDR_W  address of the presented or next-fetched instruction

Behaviour:
- Reset (async, resetn low):
  - pc=RESET_PC, fetch_addr=RESET_PC, ir=0.
  - instr_valid=0, mem_req=0, state=FETCH.
  - All outputs reach reset values immediately. The memory shares resetn, so no pre-reset response can arrive.
- FETCH state:
  - mem_req=1, mem_addr=fetch_addr (registered copy of pc taken on entry).
  - On mem_rvalid: ir<=mem_rdata, instr_valid<=1, next state HOLD.
  - Latency: rvalid in cycle N gives instruction/instr_valid in cycle N+1.
  - Minimum fetch-to-fetch time: 1 cycle FETCH + 1 cycle HOLD.
- HOLD state:
  - mem_req=0. ir is stable and instruction=ir.
  - pc_inc: pc<=pc+PC_STEP (modulo 2^ADDR_W; 0xFFFF_FFFC wraps to 0), fetch_addr<=same value, instr_valid<=0, next FETCH.
  - jump_valid: pc<=fetch_addr<={jump_target[ADDR_W-1:2],2'b00}, instr_valid<=0, next FETCH.
  - pc_inc and jump_valid in the same cycle: jump wins; the increment is dropped.
- Redirect while a fetch is outstanding (jump_valid in FETCH):
  - With mem_rvalid in the same cycle: response discarded, ir unchanged, instr_valid stays 0, pc/fetch_addr<=aligned target, state stays FETCH. The new request starts next cycle.
  - Without mem_rvalid: pc<=aligned target, next state DRAIN.
- DRAIN state:
  - mem_req=1, mem_addr=old fetch_addr (protocol requires a stable address).
  - On mem_rvalid: data discarded, fetch_addr<=pc, next FETCH.
  - A further jump_valid in DRAIN updates pc only (last jump wins); state stays DRAIN.
- Ignored inputs:
  - pc_inc outside HOLD is ignored; a controlpath protocol violation is flagged by an assertion.
  - mem_rvalid in HOLD is ignored (no outstanding request).
- Low bits of jump_target[1:0] are forced to zero silently.
- At most one request is outstanding at any time.
- mem_addr is driven only from a register, never combinationally from jump_target.

Decomposition:
- Shared package rapids_pkg gets:
  - fetch_state_t enum {FETCH, DRAIN, HOLD}, 2 bits
  - INSTR_W=32
  - NOP_WORD=32'h0
- Single flat module. The pc-next mux (jump/inc/hold) may be a small function inside it; no sub-module is needed.

Test Plan:
- Reset release with memory returning rvalid after 2 cycles, rdata=32'hDEAD_0001 -> mem_addr=0 while req high; instr_valid=1 and instruction=32'hDEAD_0001 the cycle after rvalid; pc=0.
- Three pc_inc pulses, each in HOLD -> fetch addresses 4, 8, 12 in order; pc=12; instruction between fetches = 0 with instr_valid=0.
- Force pc=32'hFFFF_FFFC via jump, then pc_inc -> next mem_addr=0 (wrap).
- jump_valid(target=32'h0000_0103) in FETCH, rvalid 3 cycles later with rdata=32'hBAD -> BAD never presented; mem_addr held at the old address until rvalid; next request at 32'h100; instr_valid only after the 32'h100 response.
- pc_inc and jump_valid(target=32'h40) together in HOLD -> next fetch at 32'h40, not pc+4.
- Assert resetn low mid-DRAIN -> mem_req=0, instr_valid=0, pc=RESET_PC immediately; after release, fetch restarts at RESET_PC.
